// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry, the hardwired zero
// register address and the register address/data typedefs.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    // True when addr names the hardwired zero register and that feature is on.
    function automatic logic is_hard_zero(input int zero_en, input int addr);
        return (zero_en != 0) && (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: writeback bypass, hardwired-zero override and
// busy reporting for a single address.
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              busy_bit,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic hit;
    logic zero;

    assign hit  = wb_en && (wb_addr == rd_addr);
    assign zero = is_hard_zero(ZERO_REG, int'(rd_addr));

    always_comb begin
        rd_data = hit ? wb_data : arr_data;
        rd_busy = busy_bit && !hit;
        // The zero register wins over a same-cycle bypass.
        if (zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a per-register busy scoreboard: decode marks
// destinations busy at issue, writeback clears them, read ports expose hazards.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_dst,
    output logic                  iss_ok,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [ADDR_W:0]       pend_cnt,
    output logic                  err
);

    localparam int NREGS  = 1 << ADDR_W;
    localparam int MAXCNT = (ZERO_REG != 0) ? NREGS - 1 : NREGS;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;
    logic              err_q, err_d;

    logic wb_zero, iss_zero;
    logic wb_act, wb_clr, iss_act;

    assign wb_zero  = is_hard_zero(ZERO_REG, int'(wb_addr));
    assign iss_zero = is_hard_zero(ZERO_REG, int'(iss_dst));
    assign wb_act   = wb_en && !wb_zero;
    assign wb_clr   = wb_act && busy_q[wb_addr];

    // A writeback landing on the issuing destination this cycle retires the
    // older producer, so the new issue is not a WAW hazard.
    assign iss_ok   = !busy_q[iss_dst] || (wb_en && (wb_addr == iss_dst));
    assign iss_act  = iss_en && iss_ok && !iss_zero;

    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        err_d      = err_q;
        pend_cnt_d = pend_cnt_q;

        if (wb_act) begin
            regs_d[wb_addr] = wb_data;
            busy_d[wb_addr] = 1'b0;
            if (!busy_q[wb_addr]) begin
                err_d = 1'b1;
            end
        end

        // Applied after the writeback so a same-register issue leaves it busy.
        if (iss_act) begin
            busy_d[iss_dst] = 1'b1;
        end
        if (iss_en && !iss_ok) begin
            err_d = 1'b1;
        end

        case ({iss_act, wb_clr})
            2'b10: begin
                if (pend_cnt_q < (ADDR_W+1)'(MAXCNT)) begin
                    pend_cnt_d = pend_cnt_q + (ADDR_W+1)'(1);
                end
            end
            2'b01: begin
                if (pend_cnt_q != '0) begin
                    pend_cnt_d = pend_cnt_q - (ADDR_W+1)'(1);
                end
            end
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            pend_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
            err_q      <= err_d;
        end
    end

    assign pend_cnt = pend_cnt_q;
    assign err      = err_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;
        assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .rd_addr  (addr_k),
            .arr_data (regs_q[addr_k]),
            .busy_bit (busy_q[addr_k]),
            .wb_en    (wb_en),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .rd_data  (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule
